// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   NOP_INST       : instruction presented to decode when the fetch queue is empty
//   fetch_entry_t  : {pc, inst} record for the default 32-bit configuration
//   ptr_w()        : pointer width for a power-of-two queue depth
package fetch_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int          FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           inst;
  } fetch_entry_t;

  // Depth 2 still needs one pointer bit, so clamp below at 1.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with single-cycle flush, used to buffer fetched
// {pc, inst} entries between the memory response and decode.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   flush            : drop all entries (wins over push/pop)
//   push, push_data  : enqueue request and entry
//   pop              : dequeue request (ignored when empty)
//   head_data        : oldest entry (undefined content when empty)
//   count            : number of stored entries (0..DEPTH)
//   full, empty      : occupancy flags
// A push while full is accepted only together with a pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [PW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction-fetch stage: PC register, redirect handling, one
// outstanding request to a variable-latency instruction memory, and a
// flushable fetch queue feeding decode.
// Ports:
//   clk, reset_n                   : clock, asynchronous active-low reset
//   redirect_valid, redirect_pc    : taken branch/jump; flushes the stage
//   imem_req_valid/ready/addr      : request channel (addr = fetch PC)
//   imem_rsp_valid, imem_rsp_data  : in-order response, one per request
//   id_valid/ready, id_pc, id_inst : head of fetch queue to decode
//   misalign_err                   : sticky misaligned-redirect flag
// Optional build macro IF_MISALIGN_CHECK_EN: a redirect to a non word-aligned
// PC sets misalign_err and halts fetch until an aligned redirect. Without it,
// redirect_pc[1:0] is ignored and misalign_err is tied low.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic            misalign_err
);

  localparam int PW = ptr_w(FQ_DEPTH);
  localparam logic [PW+1:0] OCC_LIMIT = (PW+2)'(FQ_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] redirect_target;
  logic            halt;
  logic            req_fire;
  logic [PW+1:0]   occupancy;

  entry_t          q_push_entry, q_head;
  logic            q_push, q_pop, q_full, q_empty;
  logic [PW:0]     q_count;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redirect_target = redirect_pc;
  assign halt            = misalign_q;
  assign misalign_err    = misalign_q;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid) misalign_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end
`else
  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign halt            = 1'b0;
  assign misalign_err    = 1'b0;
`endif

  // Queue slots already claimed: stored entries plus the response still in
  // flight. Issue only when a slot remains, so a push can never overflow.
  assign occupancy = {1'b0, q_count} + {{(PW+1){1'b0}}, outstanding_q};

  assign imem_req_valid = reset_n & ~redirect_valid & ~halt & ~q_full
                        & (~outstanding_q | imem_rsp_valid)
                        & (occupancy < OCC_LIMIT);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (imem_rsp_valid) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      // The in-flight response belongs to the old path; mark it for dropping.
      if (outstanding_q && !imem_rsp_valid) discard_d = 1'b1;
    end else if (req_fire) begin
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
      req_pc_d      = fetch_pc_q;
      outstanding_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  // Response -> fetch queue boundary (registered enqueue, no bypass).
  assign q_push            = imem_rsp_valid & ~discard_q & ~redirect_valid;
  assign q_push_entry.pc   = req_pc_q;
  assign q_push_entry.inst = imem_rsp_data;
  assign q_pop             = ~q_empty & id_ready;

  fetch_queue #(
    .DEPTH(FQ_DEPTH),
    .W    (XLEN + 32)
  ) u_queue (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (redirect_valid),
    .push     (q_push),
    .push_data(q_push_entry),
    .pop      (q_pop),
    .head_data(q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign id_valid = ~q_empty;
  assign id_pc    = q_empty ? '0 : q_head.pc;
  assign id_inst  = q_empty ? NOP_INST : q_head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table and sequences for the
// fetch/redirect corner cases plus randomized traffic against a queue-based
// behavioural model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int XLEN     = 32;
  localparam int FQ_DEPTH = 4;

  logic            clk;
  logic            reset_n;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_inst;
  logic            misalign_err;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Memory contents: a fixed scrambling of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of fetched entries plus fetch bookkeeping.
  fetch_entry_t r_q[$];
  logic [31:0]  r_fetch_pc, r_req_pc;
  bit           r_out, r_disc, r_err;

  // Memory model: at most one pending request, configurable latency.
  bit           m_pend;
  logic [31:0]  m_addr;
  int           m_wait;
  int           m_lat;
  bit           m_lat_rand;
  bit           rdy_rand;

  // Stimulus for the next cycle.
  bit           s_redir;
  logic [31:0]  s_rpc;
  bit           s_id_ready;

  // Observations from the last cycle.
  bit           o_acc, o_rsp, o_req_valid, o_id_valid, o_err;
  logic [31:0]  o_acc_addr, o_req_addr, o_id_pc;
  logic [31:0]  acc_log[$];
  bit           st_pend;
  logic [31:0]  st_addr;

  task automatic model_step(input bit acc, input bit pop, input bit rsp, input logic [31:0] data);
    fetch_entry_t e;
    if (s_redir) begin
      r_q.delete();
      r_disc = r_out && !rsp;
      if (rsp) r_out = 0;
`ifdef IF_MISALIGN_CHECK_EN
      r_fetch_pc = s_rpc;
      r_err      = (s_rpc[1:0] != 2'b00);
`else
      r_fetch_pc = s_rpc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (pop && r_q.size() > 0) void'(r_q.pop_front());
      if (rsp) begin
        if (!r_disc) begin
          e.pc   = r_req_pc;
          e.inst = data;
          r_q.push_back(e);
        end
        r_disc = 0;
        r_out  = 0;
      end
      if (acc) begin
        r_out      = 1;
        r_req_pc   = r_fetch_pc;
        r_fetch_pc = r_fetch_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: entered at a negedge, drives inputs, checks outputs
  // against the model, advances models, returns at the next negedge.
  task automatic cycle();
    bit          exp_rv, exp_iv;
    logic [31:0] exp_pc, exp_inst;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (m_pend) begin
      if (m_wait <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(m_addr);
      end else begin
        m_wait--;
      end
    end
    imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    redirect_valid = s_redir;
    redirect_pc    = s_rpc;
    id_ready       = s_id_ready;
    #1;
    exp_rv = !s_redir && !r_err && (!r_out || imem_rsp_valid)
             && (r_q.size() + int'(r_out) < FQ_DEPTH);
    exp_iv   = (r_q.size() > 0);
    exp_pc   = exp_iv ? r_q[0].pc : 32'h0;
    exp_inst = exp_iv ? r_q[0].inst : NOP_INST;
    chk1("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk32("req_addr", imem_req_addr, r_fetch_pc);
    chk1("id_valid", id_valid, exp_iv);
    chk32("id_pc", id_pc, exp_pc);
    chk32("id_inst", id_inst, exp_inst);
    chk1("misalign_err", misalign_err, r_err);
    if (id_valid) chk32("inst_vs_mem", id_inst, mem_word(id_pc));
    if (st_pend && !s_redir) begin
      chk1("req_hold_valid", imem_req_valid, 1'b1);
      chk32("req_hold_addr", imem_req_addr, st_addr);
    end
    o_acc       = imem_req_valid && imem_req_ready;
    o_acc_addr  = imem_req_addr;
    o_rsp       = imem_rsp_valid;
    o_req_valid = imem_req_valid;
    o_req_addr  = imem_req_addr;
    o_id_valid  = id_valid;
    o_id_pc     = id_pc;
    o_err       = misalign_err;
    st_pend     = imem_req_valid && !imem_req_ready;
    st_addr     = imem_req_addr;
    if (o_acc) acc_log.push_back(o_acc_addr);
    if (imem_rsp_valid) m_pend = 0;
    if (o_acc) begin
      m_pend = 1;
      m_addr = imem_req_addr;
      m_wait = m_lat_rand ? int'($urandom_range(1, 4)) : m_lat;
    end
    model_step(exp_rv && imem_req_ready, exp_iv && s_id_ready, imem_rsp_valid, imem_rsp_data);
    @(negedge clk);
  endtask

  // Asynchronous reset taken between clock edges; outputs checked before
  // any edge arrives. Returns at a negedge with reset released.
  task automatic do_reset();
    #2;
    reset_n        = 1'b0;
    s_redir        = 0;
    s_rpc          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk32("rst_id_pc", id_pc, 32'h0);
    chk32("rst_id_inst", id_inst, NOP_INST);
    chk1("rst_misalign", misalign_err, 1'b0);
    r_q.delete();
    r_fetch_pc = 32'h0;
    r_req_pc   = 32'h0;
    r_out = 0; r_disc = 0; r_err = 0;
    m_pend = 0; m_wait = 0;
    st_pend = 0;
    acc_log.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          id_rdy;
    bit          rv;
    logic [31:0] ra;
    bit          iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] drained[$];
  bit          found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    id_ready = 1'b0;
    s_redir = 0; s_rpc = '0; s_id_ready = 1;
    m_lat = 1; m_lat_rand = 0; rdy_rand = 0;

    // Cycle-by-cycle expectations after reset release, memory ready, latency 1.
    tbl[0] = '{1, 1, 32'h00, 0, 32'h0};
    tbl[1] = '{1, 1, 32'h04, 0, 32'h0};
    tbl[2] = '{1, 1, 32'h08, 1, 32'h0};
    tbl[3] = '{1, 1, 32'h0C, 1, 32'h4};
    tbl[4] = '{1, 1, 32'h10, 1, 32'h8};
    tbl[5] = '{1, 1, 32'h14, 1, 32'hC};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s_id_ready = tbl[i].id_rdy;
      cycle();
      chk1($sformatf("t%0d_req_valid", i), o_req_valid, tbl[i].rv);
      chk32($sformatf("t%0d_req_addr", i), o_req_addr, tbl[i].ra);
      chk1($sformatf("t%0d_id_valid", i), o_id_valid, tbl[i].iv);
      chk32($sformatf("t%0d_id_pc", i), o_id_pc, tbl[i].ipc);
    end

    // Decode stall fills the queue, issue stops; release drains in order.
    do_reset();
    s_id_ready = 0;
    repeat (10) cycle();
    chk1("p2_queue_valid", o_id_valid, 1'b1);
    chk1("p2_issue_stopped", o_req_valid, 1'b0);
    s_id_ready = 1;
    drained.delete();
    for (int i = 0; i < 20 && drained.size() < 4; i++) begin
      cycle();
      if (o_id_valid) drained.push_back(o_id_pc);
    end
    chk32("p2_drain_count", 32'(drained.size()), 32'd4);
    for (int i = 0; i < drained.size(); i++)
      chk32($sformatf("p2_drain_%0d", i), drained[i], 32'(4 * i));

    // Latency 3, redirect while the 0x8 request is in flight.
    do_reset();
    m_lat = 3;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (o_acc && o_acc_addr == 32'h8) found = 1;
    end
    chk1("p3_req8_seen", found, 1'b1);
    s_redir = 1; s_rpc = 32'h40;
    cycle();
    s_redir = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (o_id_valid) begin
        found = 1;
        chk32("p3_first_pc", o_id_pc, 32'h40);
      end
    end
    chk1("p3_id_seen", found, 1'b1);

    // Redirect coinciding with a response and a pop.
    do_reset();
    m_lat = 1;
    repeat (5) cycle();
    s_redir = 1; s_rpc = 32'h80;
    cycle();
    s_redir = 0;
    chk1("p4_rsp_in_redirect", o_rsp, 1'b1);
    chk1("p4_pop_in_redirect", o_id_valid, 1'b1);
    cycle();
    chk1("p4_empty_after", o_id_valid, 1'b0);
    chk1("p4_req_valid", o_req_valid, 1'b1);
    chk32("p4_req_addr", o_req_addr, 32'h80);

    // Address wrap at the top of the address space.
    s_redir = 1; s_rpc = 32'hFFFF_FFFC;
    cycle();
    s_redir = 0;
    acc_log.delete();
    repeat (6) cycle();
    chk1("p5_two_reqs", acc_log.size() >= 2, 1'b1);
    if (acc_log.size() >= 2) begin
      chk32("p5_addr0", acc_log[0], 32'hFFFF_FFFC);
      chk32("p5_addr1", acc_log[1], 32'h0000_0000);
    end

    // Misaligned redirect.
    s_redir = 1; s_rpc = 32'h42;
    cycle();
    s_redir = 0;
    acc_log.delete();
    repeat (4) cycle();
`ifdef IF_MISALIGN_CHECK_EN
    chk1("p6_err_set", o_err, 1'b1);
    chk32("p6_no_reqs", 32'(acc_log.size()), 32'd0);
    s_redir = 1; s_rpc = 32'h100;
    cycle();
    s_redir = 0;
    acc_log.delete();
    repeat (3) cycle();
    chk1("p6_err_clear", o_err, 1'b0);
    chk1("p6_resumed", acc_log.size() > 0, 1'b1);
    if (acc_log.size() > 0) chk32("p6_resume_addr", acc_log[0], 32'h100);
`else
    chk1("p6_err_tied", o_err, 1'b0);
    chk1("p6_fetching", acc_log.size() > 0, 1'b1);
    if (acc_log.size() > 0) chk32("p6_aligned_addr", acc_log[0], 32'h40);
`endif

    // Mid-operation reset with traffic in flight, then randomized traffic.
    do_reset();
    m_lat_rand = 1;
    rdy_rand   = 1;
    for (int i = 0; i < 3000; i++) begin
      s_id_ready = ($urandom_range(0, 3) != 0);
      s_redir    = ($urandom_range(0, 19) == 0);
      s_rpc      = $urandom;
      if ($urandom_range(0, 7) != 0) s_rpc[1:0] = 2'b00;
      cycle();
      if (i == 1500) do_reset();
    end
    s_redir = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
